// File: rtl/fir_tap_pipe.sv
// Pipelined FIR: delay line, per-tap multiply, registered adder tree, round/saturate output.
// Coefficients are double-buffered: writes go to a shadow bank, a swap copies it to active.
module fir_tap_pipe #(
    parameter int unsigned DW        = 16,
    parameter int unsigned CW        = 16,
    parameter int unsigned TAPS      = 9,
    parameter int unsigned OW        = 16,
    parameter int unsigned OUT_SHIFT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 in_valid_i,
    input  logic signed [DW-1:0] data_in,
    input  logic                 coef_we_i,
    input  logic [4:0]           coef_addr_i,
    input  logic signed [CW-1:0] coef_data_i,
    input  logic                 coef_swap_i,
    output logic                 out_valid_o,
    output logic signed [OW-1:0] data_o,
    output logic                 sat_o
);

    localparam int unsigned L  = $clog2(TAPS);
    localparam int unsigned PW = DW + CW;
    localparam int unsigned AW = PW + L;
    localparam int unsigned RW = AW + 1;

    localparam logic signed [RW-1:0] RND  = RW'((RW'(1) << OUT_SHIFT) >> 1);
    localparam logic signed [RW-1:0] OMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [RW-1:0] OMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    // Number of live nodes at a given adder-tree level (level 0 = products).
    function automatic int unsigned level_cnt(input int unsigned lvl);
        return (TAPS + (32'd1 << lvl) - 1) >> lvl;
    endfunction

    logic signed [DW-1:0] x_q      [TAPS];
    logic signed [CW-1:0] shadow_q [TAPS];
    logic signed [CW-1:0] active_q [TAPS];

    // One spare column so the pairwise reads of an odd-sized level stay in range.
    logic signed [AW-1:0] tree_d [L+1][TAPS+1];
    logic signed [AW-1:0] tree_q [L+1][TAPS+1];

    // vld_q[0]: delay line, vld_q[1+l]: tree level l.
    logic [L+1:0] vld_q;

    logic                 out_valid_q;
    logic signed [OW-1:0] data_q;
    logic                 sat_q;

    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] shifted;
    logic signed [OW-1:0] data_d;
    logic                 sat_d;

    always_comb begin
        for (int l = 0; l <= int'(L); l++) begin
            for (int i = 0; i <= int'(TAPS); i++) begin
                tree_d[l][i] = '0;
            end
        end
        for (int k = 0; k < int'(TAPS); k++) begin
            tree_d[0][k] = AW'(PW'(x_q[k]) * PW'(active_q[k]));
        end
        for (int l = 1; l <= int'(L); l++) begin
            for (int i = 0; i < int'((TAPS + 1) / 2); i++) begin
                if (i < int'(level_cnt(l))) begin
                    if (2 * i + 1 < int'(level_cnt(l - 1))) begin
                        tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
                    end else begin
                        tree_d[l][i] = tree_q[l-1][2*i];
                    end
                end
            end
        end
    end

    always_comb begin
        rnd_sum = RW'(tree_q[L][0]) + RND;
        shifted = rnd_sum >>> OUT_SHIFT;
        data_d  = shifted[OW-1:0];
        sat_d   = 1'b0;
        if (shifted > OMAX) begin
            data_d = OMAX[OW-1:0];
            sat_d  = 1'b1;
        end else if (shifted < OMIN) begin
            data_d = OMIN[OW-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                x_q[k]      <= '0;
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            for (int l = 0; l <= int'(L); l++) begin
                for (int i = 0; i <= int'(TAPS); i++) begin
                    tree_q[l][i] <= '0;
                end
            end
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sat_q       <= 1'b0;
        end else begin
            if (clr_i) begin
                for (int k = 0; k < int'(TAPS); k++) begin
                    x_q[k] <= '0;
                end
            end else if (in_valid_i) begin
                x_q[0] <= data_in;
                for (int k = 1; k < int'(TAPS); k++) begin
                    x_q[k] <= x_q[k-1];
                end
            end
            // Swap reads the pre-write shadow because both updates are non-blocking.
            if (coef_swap_i) begin
                for (int k = 0; k < int'(TAPS); k++) begin
                    active_q[k] <= shadow_q[k];
                end
            end
            if (coef_we_i) begin
                for (int k = 0; k < int'(TAPS); k++) begin
                    if (coef_addr_i == 5'(k)) begin
                        shadow_q[k] <= coef_data_i;
                    end
                end
            end
            for (int l = 0; l <= int'(L); l++) begin
                for (int i = 0; i <= int'(TAPS); i++) begin
                    tree_q[l][i] <= tree_d[l][i];
                end
            end
            vld_q       <= clr_i ? '0 : {vld_q[L:0], in_valid_i & ~clr_i};
            out_valid_q <= vld_q[L+1] & ~clr_i;
            if (vld_q[L+1] && !clr_i) begin
                data_q <= data_d;
                sat_q  <= sat_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign sat_o       = sat_q;

endmodule
